// File: rtl/xor_stream_encryptor_pkg.sv
// Shared definitions for the XOR stream encryptor: default widths,
// FSM state encoding and the pass counter width.
package xor_stream_encryptor_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int KEY_W_DEF  = 512;
    localparam int PASS_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/xor_cipher_out_reg.sv
// Registered valid/ready output stage for ciphertext words.
// Handshake: a word moves on a clock edge where valid && ready are both high.
// Upstream ready is offered while enabled and the register is empty or being
// drained this cycle; a simultaneous drain and accept replaces the held word.
module xor_cipher_out_reg
    import xor_stream_encryptor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEnable,
    input  logic [DATA_W-1:0] iData,
    input  logic              iData_valid,
    output logic              oData_ready,
    output logic              oAccept,
    output logic [DATA_W-1:0] oData,
    output logic              oData_valid,
    input  logic              iData_ready_ds
);

    assign oData_ready = iEnable && (!oData_valid || iData_ready_ds);
    assign oAccept     = iData_valid && oData_ready;

    // Load on accept, otherwise clear valid once downstream takes the word.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData       <= '0;
            oData_valid <= 1'b0;
        end else if (oAccept) begin
            oData       <= iData;
            oData_valid <= 1'b1;
        end else if (iData_ready_ds) begin
            oData_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/xor_stream_encryptor.sv
// XOR stream encryptor: snapshots the assembled key and XORs plaintext words
// with consecutive key segments, cycling through all segments of the key.
// Optional build macro: XOR_CIPHER_ROTATE_EN rotates the key register left by
// one bit each time the segment index wraps.
// oDbgState exposes the FSM state for observation.
module xor_stream_encryptor
    import xor_stream_encryptor_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int KEY_W  = KEY_W_DEF,
    localparam int SEGS   = KEY_W / DATA_W,
    localparam int SEG_W  = $clog2(SEGS)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [KEY_W-1:0]  iAssembled_key,
    input  logic              iCan_encrypt,
    input  logic [DATA_W-1:0] iData,
    input  logic              iData_valid,
    output logic              oData_ready,
    output logic [DATA_W-1:0] oCipher,
    output logic              oCipher_valid,
    input  logic              iCipher_ready,
    output logic [SEG_W-1:0]  oSeg_index,
    output logic [PASS_W-1:0] oPass_count,
    output logic              oKey_loaded,
    output logic [1:0]        oDbgState
);

    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGS - 1);

    state_t             state;
    logic [KEY_W-1:0]   keyReg;
    logic [SEG_W-1:0]   segIdx;
    logic [PASS_W-1:0]  passCount;
    logic               keyLoaded;
    logic [DATA_W-1:0]  keySeg;
    logic               runEnable;
    logic               accept;

    assign oSeg_index  = segIdx;
    assign oPass_count = passCount;
    assign oKey_loaded = keyLoaded;
    assign oDbgState   = state;

    // Segment applied to the word accepted this cycle.
    assign keySeg    = keyReg[int'(segIdx)*DATA_W +: DATA_W];
    // Input side closes the same cycle the key-complete flag falls.
    assign runEnable = (state == RUN) && iCan_encrypt;

    xor_cipher_out_reg #(
        .DATA_W (DATA_W)
    ) uOutReg (
        .iClk           (iClk),
        .iRst           (iRst),
        .iEnable        (runEnable),
        .iData          (iData ^ keySeg),
        .iData_valid    (iData_valid),
        .oData_ready    (oData_ready),
        .oAccept        (accept),
        .oData          (oCipher),
        .oData_valid    (oCipher_valid),
        .iData_ready_ds (iCipher_ready)
    );

    // FSM, key snapshot, segment index and pass counter.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            keyReg    <= '0;
            segIdx    <= '0;
            passCount <= '0;
            keyLoaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iCan_encrypt) state <= LOAD;
                end
                LOAD: begin
                    keyReg    <= iAssembled_key;
                    segIdx    <= '0;
                    keyLoaded <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (!iCan_encrypt) begin
                        state     <= IDLE;
                        segIdx    <= '0;
                        keyLoaded <= 1'b0;
                    end else if (accept) begin
                        if (segIdx == SEG_LAST) begin
                            segIdx    <= '0;
                            passCount <= passCount + 1'b1;
`ifdef XOR_CIPHER_ROTATE_EN
                            keyReg    <= {keyReg[KEY_W-2:0], keyReg[KEY_W-1]};
`else
                            keyReg    <= keyReg;
`endif
                        end else begin
                            segIdx <= segIdx + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    keyLoaded <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_stream_encryptor.sv
// Directed bench for xor_stream_encryptor with a ciphertext scoreboard.
module tb_xor_stream_encryptor;

    localparam int DATA_W = 32;
    localparam int KEY_W  = 512;

`ifdef XOR_CIPHER_ROTATE_EN
    localparam logic [31:0] ROT_EXP = 32'h0000_0002;
`else
    localparam logic [31:0] ROT_EXP = 32'h0000_0001;
`endif

    logic              iClk;
    logic              iRst;
    logic [KEY_W-1:0]  iAssembled_key;
    logic              iCan_encrypt;
    logic [DATA_W-1:0] iData;
    logic              iData_valid;
    logic              oData_ready;
    logic [DATA_W-1:0] oCipher;
    logic              oCipher_valid;
    logic              iCipher_ready;
    logic [3:0]        oSeg_index;
    logic [15:0]       oPass_count;
    logic              oKey_loaded;
    logic [1:0]        oDbgState;

    int nChecks = 0;
    int nPassed = 0;
    logic [31:0] expQ[$];
    logic [31:0] curExp;
    logic        lastAccepted;
    logic [KEY_W-1:0] key1;
    logic [KEY_W-1:0] key2;

    xor_stream_encryptor dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iAssembled_key (iAssembled_key),
        .iCan_encrypt   (iCan_encrypt),
        .iData          (iData),
        .iData_valid    (iData_valid),
        .oData_ready    (oData_ready),
        .oCipher        (oCipher),
        .oCipher_valid  (oCipher_valid),
        .iCipher_ready  (iCipher_ready),
        .oSeg_index     (oSeg_index),
        .oPass_count    (oPass_count),
        .oKey_loaded    (oKey_loaded),
        .oDbgState      (oDbgState)
    );

    // Clock and watchdog.
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPassed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Scoreboard: sampled 1 time unit before each rising edge.
    initial begin
        lastAccepted = 1'b0;
        forever begin
            @(negedge iClk);
            #4;
            if (!iRst && oCipher_valid && iCipher_ready) begin
                if (expQ.size() == 0) checkValue("extra_output", oCipher_valid, 0);
                else checkValue("cipher", oCipher, expQ.pop_front());
            end
            lastAccepted = !iRst && iData_valid && oData_ready;
            if (lastAccepted) expQ.push_back(curExp);
        end
    end

    // Present one word and return at the falling edge after it is accepted.
    task automatic sendWord(input logic [31:0] pt, input logic [31:0] ex);
        int tries;
        iData       = pt;
        curExp      = ex;
        iData_valid = 1'b1;
        tries       = 0;
        do begin
            @(negedge iClk);
            tries++;
        end while (!lastAccepted && tries < 40);
        checkValue("accept", lastAccepted, 1);
    endtask

    initial begin
        iRst = 1'b1; iCan_encrypt = 1'b0; iData = '0; iData_valid = 1'b0;
        iCipher_ready = 1'b1; iAssembled_key = '0; curExp = '0;
        for (int i = 0; i < 16; i++) begin
            key1[i*32 +: 32] = 32'(i + 1);
            key2[i*32 +: 32] = 32'hA000_0000 | 32'(i);
        end
        repeat (2) @(negedge iClk);
        #1;
        checkValue("rst_cipher", oCipher, 0);
        checkValue("rst_valid", oCipher_valid, 0);
        checkValue("rst_ready", oData_ready, 0);
        checkValue("rst_seg", oSeg_index, 0);
        checkValue("rst_pass", oPass_count, 0);
        checkValue("rst_loaded", oKey_loaded, 0);
        checkValue("rst_state", oDbgState, 0);
        iRst = 1'b0;

        // Key-complete rising: LOAD next cycle, ready one cycle after that.
        @(negedge iClk);
        iAssembled_key = key1;
        iCan_encrypt   = 1'b1;
        #1 checkValue("ready_c0", oData_ready, 0);
        @(negedge iClk);
        #1 checkValue("ready_c1", oData_ready, 0);
        checkValue("state_load", oDbgState, 1);
        @(negedge iClk);
        #1 checkValue("ready_c2", oData_ready, 1);
        checkValue("loaded_run", oKey_loaded, 1);
        checkValue("seg_start", oSeg_index, 0);

        // Full pass of all-ones plaintext.
        for (int i = 0; i < 16; i++) sendWord(32'hFFFF_FFFF, 32'hFFFF_FFFF ^ 32'(i + 1));
        iData_valid = 1'b0;
        #1 checkValue("pass_after16", oPass_count, 1);
        checkValue("seg_after16", oSeg_index, 0);

        // Downstream stall holds the word and blocks input.
        sendWord(32'h1234_5678, 32'h1234_5679);
        iData_valid   = 1'b0;
        iCipher_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkValue("stall_cipher", oCipher, 32'h1234_5679);
            checkValue("stall_valid", oCipher_valid, 1);
            checkValue("stall_ready", oData_ready, 0);
            @(negedge iClk);
        end
        iCipher_ready = 1'b1;
        sendWord(32'hA5A5_A5A5, 32'hA5A5_A5A7);
        sendWord(32'h0F0F_0F0F, 32'h0F0F_0F0C);

        // Key input changes during RUN are ignored.
        iAssembled_key = key2;
        sendWord(32'h0, 32'h0000_0004);
        sendWord(32'h0, 32'h0000_0005);
        iData_valid = 1'b0;
        #1 checkValue("seg_5", oSeg_index, 5);

        // Drop key-complete with a word pending.
        for (int i = 0; i < 5; i++) sendWord(32'h100, 32'h100 ^ 32'(i + 6));
        iData_valid   = 1'b0;
        iCipher_ready = 1'b0;
        iCan_encrypt  = 1'b0;
        #1 checkValue("drop_ready", oData_ready, 0);
        @(negedge iClk);
        #1 checkValue("drop_state", oDbgState, 0);
        checkValue("drop_seg", oSeg_index, 0);
        checkValue("drop_loaded", oKey_loaded, 0);
        checkValue("drop_valid", oCipher_valid, 1);
        checkValue("drop_cipher", oCipher, 32'h0000_010A);
        @(negedge iClk);
        #1 checkValue("drop_hold", oCipher_valid, 1);
        iCipher_ready = 1'b1;
        @(negedge iClk);
        #1 checkValue("drop_drained", oCipher_valid, 0);

        // Re-entry with a fresh snapshot.
        iCan_encrypt = 1'b1;
        repeat (2) @(negedge iClk);
        #1 checkValue("reentry_ready", oData_ready, 1);
        checkValue("reentry_seg", oSeg_index, 0);
        sendWord(32'h0, 32'hA000_0000);
        sendWord(32'h0, 32'hA000_0001);
        iData_valid = 1'b0;
        #1 checkValue("reentry_pass", oPass_count, 1);
        repeat (2) @(negedge iClk);
        checkValue("sb_empty", expQ.size(), 0);

        // Keystream across a wrap with a single key bit.
        iRst = 1'b1; iCan_encrypt = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
        iAssembled_key = 512'h1;
        iCan_encrypt   = 1'b1;
        repeat (2) @(negedge iClk);
        for (int i = 0; i < 16; i++) sendWord(32'h0, (i == 0) ? 32'h1 : 32'h0);
        #1 checkValue("rot_pass", oPass_count, 1);
        sendWord(32'h0, ROT_EXP);
        iData_valid   = 1'b0;
        iCipher_ready = 1'b0;
        #1 checkValue("pend_valid", oCipher_valid, 1);
        checkValue("pend_cipher", oCipher, ROT_EXP);

        // Reset with a pending output discards it.
        iRst = 1'b1;
        @(negedge iClk);
        expQ.delete();
        #1 checkValue("mrst_cipher", oCipher, 0);
        checkValue("mrst_valid", oCipher_valid, 0);
        checkValue("mrst_ready", oData_ready, 0);
        checkValue("mrst_seg", oSeg_index, 0);
        checkValue("mrst_pass", oPass_count, 0);
        checkValue("mrst_loaded", oKey_loaded, 0);
        checkValue("mrst_state", oDbgState, 0);
        iRst = 1'b0;
        @(negedge iClk);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
